// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths and arbiter state encoding for the core/host SRAM arbiter.
package ram_arbiter_pkg;
  localparam int DEF_ADDR_W = 15;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, PEND, STALL, CAPT, ACK} state_t;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous SRAM between the core (priority) and a host port,
// forcing a single core freeze cycle when a host request has starved too long.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_oe,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ce,
  input  logic              h_req,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_ack,
  output logic              h_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic wr_q, post_stall, core_busy, host_own, starved;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, hold;
  assign core_busy = core_oe | core_we;
  assign starved = 32'(cnt) >= STARVE_LIMIT;
  assign host_own = state == STALL || (state == PEND && !core_busy);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = h_req ? PEND : IDLE;
      PEND:    next = !core_busy ? CAPT : starved ? STALL : PEND;
      STALL:   next = CAPT;
      CAPT:    next = ACK;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      h_rdata <= '0;
      post_stall <= 1'b0;
    end else begin
      state <= next;
      post_stall <= state == STALL;
      if (state == IDLE) cnt <= '0;
      else if (state == PEND && core_busy && !starved) cnt <= &cnt ? cnt : cnt + 1'b1;
      if (state == STALL) hold <= ram_rdata;
      if (state == CAPT && !wr_q) h_rdata <= ram_rdata;
    end
  always_ff @(posedge clk)
    if (state == IDLE && h_req) begin
      wr_q <= h_wr;
      addr_q <= h_addr;
      wdata_q <= h_wdata;
    end
  // The read the core issued just before the freeze returns during STALL; replay it afterwards.
  assign core_rdata = post_stall ? hold : ram_rdata;
  assign core_ce = state != STALL;
  assign h_ack = state == ACK;
  assign h_busy = state != IDLE;
  assign ram_addr = host_own ? addr_q : core_addr;
  assign ram_wdata = host_own ? wdata_q : core_wdata;
  assign ram_we = host_own ? wr_q : core_we;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single synchronous 8-bit SRAM between the CPU core and a host/loader port (debug, program upload, video readout).
- The core always has priority. Host accesses are slotted into cycles where the core performs no RAM access.
- If the host waits too long, the arbiter freezes the core for exactly one cycle with a clock-enable and completes the host access in that cycle.
- Sits between the core's RAM-side signals (OE/WE, address, BUS) and the RAM macro.

Parameters:
- ADDR_W, 15, RAM address width (32K x 8).
- STARVE_LIMIT, 8, number of core-busy cycles a pending host request tolerates before a stall cycle is forced.
- CNT_W, 4, width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- CORE_OE  input  1  core RAM read this cycle.
- CORE_WE  input  1  core RAM write this cycle.
- CORE_ADDR  input  ADDR_W  core RAM address.
- CORE_WDATA  input  8  core write data (accumulator BUS).
- CORE_RDATA  output  8  read data to core.
- CORE_CE  output  1  core clock enable; 0 freezes the core for that cycle.
- H_REQ  input  1  host request, level.
- H_WR  input  1  1 = write, 0 = read; sampled on accept.
- H_ADDR  input  ADDR_W  host address; sampled on accept.
- H_WDATA  input  8  host write data; sampled on accept.
- H_RDATA  output  8  host read data, registered.
- H_ACK  output  1  one-cycle completion pulse.
- H_BUSY  output  1  request accepted and not yet acknowledged.
- RAM_ADDR  output  ADDR_W  RAM address.
- RAM_WDATA  output  8  RAM write data.
- RAM_WE  output  1  RAM write strobe.
- RAM_RDATA  input  8  RAM read data; valid one cycle after the address is presented.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE, counter = 0, HOLD = 0.
  - H_ACK = 0, H_BUSY = 0, H_RDATA = 0, CORE_CE = 1.
- States:
  - IDLE: if H_REQ=1, latch H_WR/H_ADDR/H_WDATA, clear counter, go to PEND.
  - PEND:
    - If CORE_OE=0 and CORE_WE=0, the host owns the RAM this cycle; go to CAPT.
    - Else, if counter >= STARVE_LIMIT, go to STALL; otherwise counter += 1 (saturating).
  - STALL: CORE_CE=0; host owns the RAM; capture RAM_RDATA into HOLD; go to CAPT.
  - CAPT: if the latched op is a read, H_RDATA <= RAM_RDATA; go to ACK.
  - ACK: H_ACK=1 for this one cycle; go to IDLE.
- H_BUSY = 1 in PEND, STALL, CAPT and ACK; 0 in IDLE.
- RAM mux (combinational):
  - When the host owns the RAM: RAM_ADDR/RAM_WDATA come from the latched host request; RAM_WE = latched H_WR.
  - Otherwise they come from the core, and RAM_WE = CORE_WE.
  - RAM_WE is never asserted by the core during STALL.
- CORE_RDATA = HOLD in the cycle immediately following STALL; otherwise CORE_RDATA = RAM_RDATA. This preserves the core's in-flight read across the freeze.
- A frozen core re-presents the same access in the cycle after STALL; the arbiter serves it normally.
- Latency from the accept edge to H_ACK:
  - Best case: 3 cycles.
  - Worst case: STARVE_LIMIT + 4 cycles.
- STARVE_LIMIT = 0: stall on the first core-busy PEND cycle.
- The host must drop H_REQ in the H_ACK cycle. If H_REQ is still high in IDLE, it is accepted as a new request.
- H_REQ changes while H_BUSY=1 are ignored.
- A host write completes even if the core later writes the same address. Ordering is by RAM-cycle order.
- RST asserted mid-operation: the pending host request is discarded with no ACK; CORE_CE returns to 1 immediately.

Decomposition:
- Shared package:
  - State encoding constants (IDLE, PEND, STALL, CAPT, ACK).
  - Default ADDR_W and data width 8, shared with the core's memory interface.
- No sub-module needed. The starvation counter can optionally be split out as arb_starve_cnt (saturating counter with clear, increment and >=-compare).

Test Plan:
- Core idle, host reads 0x1234, which was preloaded with 0xA5 -> H_ACK three cycles after accept, H_RDATA = 0xA5, CORE_CE stays 1.
- Core OE every cycle, STARVE_LIMIT=8, host writes 0x5A to 0x0100 -> exactly one CORE_CE=0 cycle after 8 waits; H_ACK at accept+12; a subsequent core read of 0x0100 returns 0x5A.
- Stall while the core is reading 0x0042 (=0x77) -> in the cycle after STALL, CORE_RDATA = 0x77, not the host's data.
- Core busy for 3 cycles, then idle -> host access takes the idle slot, no stall, H_ACK at accept+6.
- RST pulsed while in PEND -> H_BUSY=0, H_ACK never pulses, CORE_CE=1, RAM contents at H_ADDR unchanged.
- H_REQ held high through ACK -> a second request is accepted in the next IDLE cycle; back-to-back ACKs are spaced >= 4 cycles apart.
